// File: rtl/spi_recv_con.sv
// Receive side of the parallel SPI-style link: synchronises the asynchronous link,
// oversamples its clock and deserialises MSB-first beats into DATA_WIDTH-bit words.
module spi_recv_con #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [LINES-1:0]      chip_data_in,
    input  logic                  chip_clk_in,
    input  logic                  chip_sel_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  frame_err_out,
    output logic                  busy_out
);

    localparam int BEATS = DATA_WIDTH / LINES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("spi_recv_con: SYNC_STAGES must be 2 or 3");
    end
    if (DATA_WIDTH % LINES != 0) begin : g_bad_width
        $error("spi_recv_con: DATA_WIDTH must be a multiple of LINES");
    end

    typedef enum logic {IDLE, RECV} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] sel_sync_q;
    logic [LINES-1:0]       data_sync_q [SYNC_STAGES];
    logic                   clk_prev_q;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   vld_q, vld_d;
    logic                   err_q, err_d;

    logic                   clk_s, sel_s, rise;
    logic [LINES-1:0]       data_s;
    logic [DATA_WIDTH-1:0]  shifted;

    // All three chains share one depth so a beat's data and clock edge arrive together.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clk_sync_q <= '0;
            sel_sync_q <= '1;
            clk_prev_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
        end else begin
            clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], chip_clk_in};
            sel_sync_q     <= {sel_sync_q[SYNC_STAGES-2:0], chip_sel_in};
            data_sync_q[0] <= chip_data_in;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
            clk_prev_q     <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign sel_s  = sel_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign rise   = clk_s & ~clk_prev_q;

    if (BEATS == 1) begin : g_one_beat
        assign shifted = data_s;
    end else begin : g_multi_beat
        assign shifted = {shift_q[DATA_WIDTH-LINES-1:0], data_s};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // Select release takes priority over a coincident edge; the word completes in the edge cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sel_s) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            RECV: begin
                if (sel_s) begin
                    state_d = IDLE;
                    err_d   = (cnt_q != '0);
                end else if (rise) begin
                    shift_d = shifted;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d  = '0;
                        data_d = shifted;
                        vld_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out       = data_q;
    assign data_valid_out = vld_q;
    assign frame_err_out  = err_q;
    assign busy_out       = (state_q == RECV);

endmodule

// File: tb/tb_spi_recv_con.sv
// Directed self-checking bench for spi_recv_con (8-bit words over 4 lines, 2-stage sync).
module tb_spi_recv_con;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [3:0] chip_data_in;
    logic       chip_clk_in;
    logic       chip_sel_in;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic       frame_err_out;
    logic       busy_out;

    spi_recv_con #(.DATA_WIDTH(8), .LINES(4), .SYNC_STAGES(2)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .chip_data_in  (chip_data_in),
        .chip_clk_in   (chip_clk_in),
        .chip_sel_in   (chip_sel_in),
        .data_out      (data_out),
        .data_valid_out(data_valid_out),
        .frame_err_out (frame_err_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] obs_data[$];
    int         obs_cyc[$];
    logic [7:0] exp_data[$];
    int         exp_cyc[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in) begin
        #1;
        if (data_valid_out === 1'b1) begin
            vld_cnt++;
            obs_data.push_back(data_out);
            obs_cyc.push_back(cyc);
        end
        if (frame_err_out === 1'b1) err_cnt++;
        if (busy_out === 1'b1) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        vld_cnt = 0;
        err_cnt = 0;
        busy_cnt = 0;
        obs_data.delete();
        obs_cyc.delete();
        exp_data.delete();
        exp_cyc.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // One link beat: data set during the low phase, then the clock held high.
    task automatic beat(input logic [3:0] d, input int lo, input int hi, output int rise_cyc);
        chip_data_in = d;
        wait_cyc(lo);
        chip_clk_in = 1'b1;
        rise_cyc = cyc;
        wait_cyc(hi);
        chip_clk_in = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int lo, input int hi);
        int rc;
        beat(w[7:4], lo, hi, rc);
        beat(w[3:0], lo, hi, rc);
        exp_data.push_back(w);
        exp_cyc.push_back(rc);
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, vld_cnt, exp_data.size());
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), obs_data[i], exp_data[i]);
            chk($sformatf("%s_lat%0d", tag, i), obs_cyc[i] - exp_cyc[i], 3);
        end
    endtask

    initial begin
        int rc;
        rst_in = 1'b1;
        chip_data_in = 4'h0;
        chip_clk_in = 1'b0;
        chip_sel_in = 1'b1;
        wait_cyc(4);
        rst_in = 1'b0;
        wait_cyc(1);
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", data_valid_out, 1'b0);
        chk("rst_err", frame_err_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);

        // Single word
        clear_mon();
        chip_sel_in = 1'b0;
        wait_cyc(4);
        chk("single_busy", busy_out, 1'b1);
        send_word(8'hA5, 3, 3);
        wait_cyc(3);
        chip_sel_in = 1'b1;
        wait_cyc(6);
        check_words("single");
        chk("single_out", data_out, 8'hA5);
        chk("single_err", err_cnt, 0);
        chk("single_idle", busy_out, 1'b0);

        // Back-to-back words in one select window
        clear_mon();
        chip_sel_in = 1'b0;
        wait_cyc(4);
        send_word(8'h3C, 3, 3);
        send_word(8'hF0, 3, 3);
        wait_cyc(3);
        chip_sel_in = 1'b1;
        wait_cyc(6);
        check_words("b2b");
        chk("b2b_err", err_cnt, 0);

        // Abort after one beat
        clear_mon();
        chip_sel_in = 1'b0;
        wait_cyc(4);
        beat(4'h7, 3, 3, rc);
        wait_cyc(3);
        chip_sel_in = 1'b1;
        wait_cyc(6);
        chk("abort_err", err_cnt, 1);
        chk("abort_vld", vld_cnt, 0);
        chk("abort_hold", data_out, 8'hF0);

        // Link traffic with select high is ignored
        clear_mon();
        for (int i = 0; i < 10; i++) beat(4'hF, 3, 3, rc);
        wait_cyc(6);
        chk("ign_vld", vld_cnt, 0);
        chk("ign_err", err_cnt, 0);
        chk("ign_busy", busy_cnt, 0);

        // Reset mid-word with select held low
        clear_mon();
        chip_sel_in = 1'b0;
        wait_cyc(4);
        beat(4'h9, 3, 3, rc);
        wait_cyc(2);
        rst_in = 1'b1;
        wait_cyc(2);
        rst_in = 1'b0;
        wait_cyc(1);
        chk("rstmid_data", data_out, 8'h00);
        send_word(8'h12, 4, 3);
        wait_cyc(3);
        chip_sel_in = 1'b1;
        wait_cyc(6);
        check_words("rstmid");
        chk("rstmid_out", data_out, 8'h12);
        chk("rstmid_err", err_cnt, 0);

        // Minimum link period: 2 low / 2 high
        clear_mon();
        chip_sel_in = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 16; i++) send_word(8'($urandom_range(0, 255)), 2, 2);
        wait_cyc(4);
        chip_sel_in = 1'b1;
        wait_cyc(6);
        check_words("minper");
        chk("minper_err", err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
